lsu_mem_ctrl: RTL and testbench

- Memory-stage load/store controller; sits directly downstream of the main decoder's MemWrite/MemStrobe/ResultSrc controls, which arrive via the EX/MEM pipeline register.
- Turns each load/store into one word-aligned bus transaction with byte strobes, using a req/ack handshake with variable latency.
- Replicates store data, then extracts and sign/zero-extends load data.
- Stalls the pipeline until the transaction finishes.

---
 rtl/lsu_mem_ctrl.sv | 94 +++++++++
 tb/tb_lsu_mem_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: MEM-stage load/store controller (req/ack bus, strobes, extension); optional LSU_MISALIGN_TRAP_EN
module lsu_mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [1:0]            MemStrobeM,
  input  logic                  LoadUnsignedM,
  input  logic [ADDR_WIDTH-1:0] ALUResultM,
  input  logic [31:0]           WriteDataM,
  output logic [31:0]           ReadDataM,
  output logic                  StallMem,
  output logic                  MisalignM,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_wstrb,
  output logic [31:0]           bus_wdata,
  input  logic [31:0]           bus_rdata,
  input  logic                  bus_ack
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic       op, trap;
  logic [1:0] a_lo, size, lo;
  logic       uns;
  logic [3:0] strb;
  logic [31:0] wdata, ext;
  logic [15:0] lane;
  assign op = (MemReadM | MemWriteM) && MemStrobeM != 2'b00;
  assign bus_req = state == BUSY;
`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = op && ((MemStrobeM == 2'b10 && ALUResultM[0]) || (MemStrobeM == 2'b11 && ALUResultM[1:0] != 2'b00));
  assign a_lo = ALUResultM[1:0];
  // misalignment pulse is registered so it lines up with the DONE cycle
  always_ff @(posedge clk)
    MisalignM <= rst_n && state == IDLE && trap;
`else
  assign trap = 1'b0;
  assign a_lo = MemStrobeM == 2'b11 ? 2'b00 : MemStrobeM == 2'b10 ? {ALUResultM[1], 1'b0} : ALUResultM[1:0];
  assign MisalignM = 1'b0;
`endif
  // lane strobes, replicated store data and extended load lane
  always_comb begin
    strb = !MemWriteM ? 4'b0000 : MemStrobeM == 2'b01 ? 4'b0001 << a_lo : MemStrobeM == 2'b10 ? 4'b0011 << a_lo : 4'b1111;
    wdata = MemStrobeM == 2'b01 ? {4{WriteDataM[7:0]}} : MemStrobeM == 2'b10 ? {2{WriteDataM[15:0]}} : WriteDataM;
    lane = 16'(bus_rdata >> {lo, 3'b000});
    ext = size == 2'b01 ? {{24{lane[7] & ~uns}}, lane[7:0]} : size == 2'b10 ? {{16{lane[15] & ~uns}}, lane} : bus_rdata;
  end
  // next-state and pipeline stall
  always_comb begin
    state_nx = state;
    StallMem = 1'b0;
    case (state)
      IDLE: begin
        StallMem = op;
        state_nx = !op ? IDLE : trap ? DONE : BUSY;
      end
      BUSY: begin
        StallMem = 1'b1;
        state_nx = bus_ack ? DONE : BUSY;
      end
      default: state_nx = IDLE;
    endcase
  end
  // state, bus request registers and load result
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_wstrb <= 4'b0000;
      bus_wdata <= 32'b0;
      ReadDataM <= 32'b0;
      size <= 2'b00;
      lo <= 2'b00;
      uns <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && op && !trap) begin
        bus_we <= MemWriteM;
        bus_addr <= {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
        bus_wstrb <= strb;
        bus_wdata <= wdata;
        size <= MemStrobeM;
        lo <= a_lo;
        uns <= LoadUnsignedM;
      end
      if (state == IDLE && trap) ReadDataM <= 32'b0;
      if (state == BUSY && bus_ack && !bus_we) ReadDataM <= ext;
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed self-checking bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemReadM, MemWriteM, LoadUnsignedM, bus_ack;
  logic [1:0]  MemStrobeM;
  logic [31:0] ALUResultM, WriteDataM, bus_rdata;
  logic [31:0] ReadDataM, bus_addr, bus_wdata;
  logic        StallMem, MisalignM, bus_req, bus_we;
  logic [3:0]  bus_wstrb;
  int checks = 0, passes = 0, fails = 0;
  int st, rq;

  lsu_mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .MemStrobeM(MemStrobeM), .LoadUnsignedM(LoadUnsignedM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .StallMem(StallMem), .MisalignM(MisalignM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic rd, input logic wr, input logic [1:0] sz, input logic u,
                        input logic [31:0] addr, input logic [31:0] wd);
    MemReadM = rd; MemWriteM = wr; MemStrobeM = sz; LoadUnsignedM = u;
    ALUResultM = addr; WriteDataM = wd;
  endtask

  task automatic idle();
    @(negedge clk);
    set_in(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    bus_ack = 1'b0;
    #1;
  endtask

  task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz, input logic u,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                       input int lat, output int stall_n, output int req_n);
    int busy;
    logic done;
    @(negedge clk);
    set_in(rd, wr, sz, u, addr, wd);
    bus_rdata = rdata;
    bus_ack = 1'b0;
    stall_n = 0; req_n = 0; busy = 0; done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (StallMem) stall_n++;
      if (bus_req) req_n++;
      if (!StallMem) begin
        done = 1'b1;
        break;
      end
      if (bus_req) begin
        if (busy == lat) bus_ack = 1'b1;
        busy++;
      end
      @(negedge clk);
      bus_ack = 1'b0;
    end
    check("op_completes", {31'b0, done}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus_ack = 1'b0;
    bus_rdata = 32'h0;
    set_in(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", {31'b0, bus_req}, 32'd0);
    check("rst_we", {31'b0, bus_we}, 32'd0);
    check("rst_addr", bus_addr, 32'h0);
    check("rst_wstrb", {28'b0, bus_wstrb}, 32'h0);
    check("rst_wdata", bus_wdata, 32'h0);
    check("rst_rdata", ReadDataM, 32'h0);
    check("rst_mis", {31'b0, MisalignM}, 32'd0);
    check("rst_stall", {31'b0, StallMem}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 2, st, rq);
    check("lw_stall", st, 32'd4);
    check("lw_req", rq, 32'd3);
    check("lw_addr", bus_addr, 32'h100);
    check("lw_wstrb", {28'b0, bus_wstrb}, 32'h0);
    check("lw_we", {31'b0, bus_we}, 32'd0);
    check("lw_data", ReadDataM, 32'hDEADBEEF);

    do_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 32'h80FF0000, 1, st, rq);
    check("lb_data", ReadDataM, 32'hFFFFFF80);
    check("lb_addr", bus_addr, 32'h100);
    do_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h103, 32'h0, 32'h80FF0000, 0, st, rq);
    check("lbu_data", ReadDataM, 32'h00000080);

    do_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h202, 32'h1234ABCD, 32'h55555555, 0, st, rq);
    check("sh_stall", st, 32'd2);
    check("sh_we", {31'b0, bus_we}, 32'd1);
    check("sh_addr", bus_addr, 32'h200);
    check("sh_wstrb", {28'b0, bus_wstrb}, 32'hC);
    check("sh_wdata", bus_wdata, 32'hABCDABCD);
    check("sh_keep", ReadDataM, 32'h00000080);

    do_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h301, 32'h000000A5, 32'h0, 0, st, rq);
    check("sb_req", rq, 32'd1);
    check("sb_wstrb", {28'b0, bus_wstrb}, 32'h2);
    check("sb_wdata", bus_wdata, 32'hA5A5A5A5);
    check("sb_addr", bus_addr, 32'h300);
    do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h304, 32'h0, 32'h00008001, 0, st, rq);
    check("lh_req", rq, 32'd1);
    check("lh_wstrb", {28'b0, bus_wstrb}, 32'h0);
    check("lh_data", ReadDataM, 32'hFFFF8001);

    do_op(1'b1, 1'b0, 2'b10, 1'b1, 32'h306, 32'h0, 32'h80017FFF, 0, st, rq);
    check("lhu_hi", ReadDataM, 32'h00008001);
    do_op(1'b0, 1'b1, 2'b11, 1'b0, 32'h400, 32'h11223344, 32'h0, 1, st, rq);
    check("sw_wstrb", {28'b0, bus_wstrb}, 32'hF);
    check("sw_wdata", bus_wdata, 32'h11223344);
    do_op(1'b1, 1'b1, 2'b01, 1'b0, 32'h010, 32'h0000007E, 32'hFFFFFFFF, 0, st, rq);
    check("rdwr_we", {31'b0, bus_we}, 32'd1);
    check("rdwr_wstrb", {28'b0, bus_wstrb}, 32'h1);
    check("rdwr_keep", ReadDataM, 32'h00008001);

    do_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h102, 32'h0, 32'hCAFEF00D, 0, st, rq);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_stall", st, 32'd1);
    check("mis_req", rq, 32'd0);
    check("mis_pulse", {31'b0, MisalignM}, 32'd1);
    check("mis_data", ReadDataM, 32'h0);
    idle();
    check("mis_end", {31'b0, MisalignM}, 32'd0);
`else
    check("mis_stall", st, 32'd2);
    check("mis_req", rq, 32'd1);
    check("mis_addr", bus_addr, 32'h100);
    check("mis_flag", {31'b0, MisalignM}, 32'd0);
    check("mis_data", ReadDataM, 32'hCAFEF00D);
    do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 32'hBEEF1234, 0, st, rq);
    check("mis_lh", ReadDataM, 32'hFFFFBEEF);
    idle();
`endif

    @(negedge clk);
    bus_rdata = 32'h12345678;
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("stray_req", {31'b0, bus_req}, 32'd0);
    check("nop_stall", {31'b0, StallMem}, 32'd0);
    @(negedge clk);
    set_in(1'b1, 1'b0, 2'b00, 1'b0, 32'h700, 32'h0);
    #1;
    check("noacc_stall", {31'b0, StallMem}, 32'd0);
    @(negedge clk);
    #1;
    check("noacc_req", {31'b0, bus_req}, 32'd0);

    @(negedge clk);
    set_in(1'b1, 1'b0, 2'b11, 1'b0, 32'h500, 32'h0);
    @(negedge clk);
    #1;
    check("mid_busy", {31'b0, bus_req}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    check("mid_req", {31'b0, bus_req}, 32'd0);
    check("mid_stall", {31'b0, StallMem}, 32'd0);
    check("mid_data", ReadDataM, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    bus_rdata = 32'hFFFFFFFF;
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("post_req", {31'b0, bus_req}, 32'd0);
    check("post_data", ReadDataM, 32'h0);
    do_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h600, 32'h0, 32'h13579BDF, 0, st, rq);
    check("post_stall", st, 32'd2);
    check("post_load", ReadDataM, 32'h13579BDF);
    idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
